// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet TX FCS controller.
//   CRC_INIT        : CRC register value at the start of every frame
//   ETH_MIN_PAYLOAD : minimum payload length before FCS (pad target)
//   FCS_BYTES       : number of FCS bytes appended to each frame
//   state_t         : controller FSM states
//   bit_reverse32   : helper that turns a normal polynomial into its reflected form
package eth_pkg;

  localparam logic [31:0] CRC_INIT        = 32'hFFFF_FFFF;
  localparam int          ETH_MIN_PAYLOAD = 60;
  localparam int          FCS_BYTES       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAD  = 2'd2,
    FCS  = 2'd3
  } state_t;

  function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_tx_fcs_ctrl_crc32.sv
// Combinational byte-wide CRC32 step (Ethernet bit order: LSB of each byte first).
// The CRC state register lives in the caller.
//   crc_in   : current CRC state
//   data     : byte to fold into the CRC
//   crc_en   : when low the state passes through unchanged
//   crc_next : next CRC state
//   crc_out  : next state in transmitted form (inverted), byte0 = crc_out[7:0]
module crc32
  import eth_pkg::*;
#(
  parameter logic [31:0] POLY = 32'h04C1_1DB7
) (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  input  logic        crc_en,
  output logic [31:0] crc_next,
  output logic [31:0] crc_out
);

  // Shifting right consumes bits LSB first, so the polynomial must be reflected.
  localparam logic [31:0] POLY_REF = bit_reverse32(POLY);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ POLY_REF;
      else      c = c >> 1;
    end
    crc_next = crc_en ? c : crc_in;
    crc_out  = ~crc_next;
  end

endmodule

// File: rtl/eth_tx_fcs_ctrl.sv
// Ethernet TX FCS controller: passes payload bytes through a single output
// register, optionally zero-pads short frames to MIN_FRAME_BYTES, then appends
// the 4-byte CRC32 FCS (byte0 first).
// Ports:
//   clk, i_reset_n      : clock, synchronous active-low reset
//   s_axis_*            : payload byte stream in (tlast on final payload byte)
//   m_axis_*            : payload/pad/FCS byte stream out (tlast on final FCS byte)
//   i_pad_en            : pad enable, sampled on the first byte of each frame
//   o_fcs               : FCS of the last completed frame, transmitted byte order
//   o_frame_done        : pulse on the handshake of the final FCS byte
//
// state | meaning
// IDLE  | waiting for the first byte of a frame
// DATA  | passing payload bytes through
// PAD   | emitting 0x00 bytes until the frame reaches MIN_FRAME_BYTES
// FCS   | emitting the four FCS bytes
module eth_tx_fcs_ctrl
  import eth_pkg::*;
#(
  parameter int          MIN_FRAME_BYTES = ETH_MIN_PAYLOAD,
  parameter logic [31:0] POLY            = 32'h04C1_1DB7
) (
  input  logic        clk,
  input  logic        i_reset_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  input  logic        i_pad_en,
  output logic [31:0] o_fcs,
  output logic        o_frame_done
);

  localparam logic [6:0] MIN_CNT  = 7'(MIN_FRAME_BYTES);
  localparam logic [1:0] FCS_LAST = 2'(FCS_BYTES - 1);

  state_t      state, state_nxt;
  logic [6:0]  cnt;
  logic [6:0]  cnt_inc;
  logic        pad_q;
  logic        pad_eff;
  logic [31:0] crc_q;
  logic [31:0] crc_next;
  logic [31:0] crc_out;
  logic [1:0]  fcs_idx;

  logic        slot_free;
  logic        accept;
  logic        load;
  logic        load_last;
  logic [7:0]  load_data;
  logic        crc_en;
  logic        fcs_latch;

  assign slot_free     = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = i_reset_n && slot_free && (state == IDLE || state == DATA);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign o_frame_done  = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  // Count of payload+pad bytes after the current load; saturates so long
  // frames never wrap into the pad decision.
  assign cnt_inc = (cnt >= MIN_CNT) ? cnt : cnt + 7'd1;
  // The first byte of a frame uses the live pad enable; later bytes the latched one.
  assign pad_eff = (state == IDLE) ? i_pad_en : pad_q;

  crc32 #(.POLY(POLY)) u_crc32 (
    .crc_in   (crc_q),
    .data     (load_data),
    .crc_en   (crc_en),
    .crc_next (crc_next),
    .crc_out  (crc_out)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_last = 1'b0;
    load_data = 8'h00;
    crc_en    = 1'b0;
    fcs_latch = 1'b0;
    unique case (state)
      IDLE, DATA: begin
        if (accept) begin
          load      = 1'b1;
          load_data = s_axis_tdata;
          crc_en    = 1'b1;
          if (s_axis_tlast) begin
            if (pad_eff && (cnt_inc < MIN_CNT)) begin
              state_nxt = PAD;
            end else begin
              state_nxt = FCS;
              fcs_latch = 1'b1;
            end
          end else begin
            state_nxt = DATA;
          end
        end
      end
      PAD: begin
        if (slot_free) begin
          load   = 1'b1;
          crc_en = 1'b1;
          if (cnt_inc >= MIN_CNT) begin
            state_nxt = FCS;
            fcs_latch = 1'b1;
          end
        end
      end
      FCS: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = o_fcs[{fcs_idx, 3'b000} +: 8];
          load_last = (fcs_idx == FCS_LAST);
          // Leaving once the final FCS byte is in the output register means
          // s_axis_tready rises exactly when that byte handshakes, so the next
          // frame can follow with no idle gap.
          if (load_last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      cnt           <= '0;
      pad_q         <= 1'b0;
      crc_q         <= CRC_INIT;
      fcs_idx       <= '0;
      o_fcs         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      crc_q <= crc_next;
      if (state == IDLE && accept) pad_q <= i_pad_en;
      if (load && state != FCS) cnt <= cnt_inc;
      if (fcs_latch) o_fcs <= crc_out;
      if (state == FCS && load) begin
        fcs_idx <= fcs_idx + 2'd1;
        if (load_last) begin
          crc_q <= CRC_INIT;
          cnt   <= '0;
        end
      end

      if (load) begin
        m_axis_tdata  <= load_data;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= load_last;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_fcs_ctrl.sv
module tb_eth_tx_fcs_ctrl;

  localparam int MIN_BYTES = 60;

  logic        clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic        i_pad_en = 1'b0;
  logic [31:0] o_fcs;
  logic        o_frame_done;

  eth_tx_fcs_ctrl #(.MIN_FRAME_BYTES(MIN_BYTES), .POLY(32'h04C11DB7)) dut (
    .clk           (clk),
    .i_reset_n     (i_reset_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .i_pad_en      (i_pad_en),
    .o_fcs         (o_fcs),
    .o_frame_done  (o_frame_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  exp_d[$];
  bit          exp_l[$];
  logic [31:0] exp_fcs[$];
  logic [7:0]  fbuf[0:255];

  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c = crc;
    for (int k = 0; k < 8; k++) begin
      if ((c[0] ^ b[k]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
      else                       c = c >> 1;
    end
    return c;
  endfunction

  // Expected wire image of a frame: payload, zero pad, FCS low byte first.
  task automatic model_frame(input int len, input bit pad, output logic [31:0] fcs);
    logic [31:0] crc = 32'hFFFFFFFF;
    logic [7:0]  b;
    int total = (pad && len < MIN_BYTES) ? MIN_BYTES : len;
    for (int i = 0; i < total; i++) begin
      b = (i < len) ? fbuf[i] : 8'h00;
      exp_d.push_back(b);
      exp_l.push_back(1'b0);
      crc = crc_step(crc, b);
    end
    fcs = ~crc;
    for (int k = 0; k < 4; k++) begin
      exp_d.push_back(fcs[8*k +: 8]);
      exp_l.push_back(k == 3);
    end
    exp_fcs.push_back(fcs);
  endtask

  // ---------------- output compare process ----------------
  int   beats = 0;
  int   done_cnt = 0;
  bit   stall = 1'b0;
  bit   have_prev = 1'b0;
  logic [7:0] prev_d;
  logic prev_l;

  initial begin
    forever begin
      @(posedge clk); #1;
      m_axis_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!i_reset_n) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        check("hold_valid", {31'b0, m_axis_tvalid}, 32'd1);
        check("hold_data", {24'b0, m_axis_tdata}, {24'b0, prev_d});
        check("hold_last", {31'b0, m_axis_tlast}, {31'b0, prev_l});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_d.size() == 0) begin
          check("unexpected_beat", {24'b0, m_axis_tdata}, 32'hFFFF_FFFF);
        end else begin
          check("tdata", {24'b0, m_axis_tdata}, {24'b0, exp_d[0]});
          check("tlast", {31'b0, m_axis_tlast}, {31'b0, exp_l[0]});
          check("frame_done", {31'b0, o_frame_done}, {31'b0, exp_l[0]});
          if (exp_l[0] && exp_fcs.size() > 0) begin
            check("o_fcs", o_fcs, exp_fcs[0]);
            void'(exp_fcs.pop_front());
          end
          void'(exp_d.pop_front());
          void'(exp_l.pop_front());
        end
        beats++;
      end else begin
        check("frame_done_idle", {31'b0, o_frame_done}, 32'd0);
      end
      if (o_frame_done) done_cnt++;
      have_prev = m_axis_tvalid && !m_axis_tready;
      prev_d = m_axis_tdata;
      prev_l = m_axis_tlast;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_frame(input int len, input bit pad, input bit gaps);
    logic [31:0] fcs;
    int to;
    @(posedge clk); #1;
    model_frame(len, pad, fcs);
    i_pad_en = pad;
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      s_axis_tdata  = fbuf[i];
      s_axis_tlast  = (i == len - 1);
      s_axis_tvalid = 1'b1;
      to = 0;
      forever begin
        @(negedge clk);
        if (s_axis_tready) break;
        to++;
        if (to > 2000) begin
          $display("FAIL s_axis_tready_timeout: got 0 expected 1");
          $fatal(1, "stuck");
        end
      end
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int to = 0;
    while (done_cnt < target && to < 20000) begin
      @(negedge clk);
      to++;
    end
    @(negedge clk);
    check("done_count", done_cnt, target);
  endtask

  task automatic load_123456789();
    for (int i = 0; i < 9; i++) fbuf[i] = 8'h31 + 8'(i);
  endtask

  task automatic load_random(input int len);
    for (int i = 0; i < len; i++) fbuf[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int b0;
    int d0;
    logic [31:0] pin_crc;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    check("rst_tlast", {31'b0, m_axis_tlast}, 32'd0);
    check("rst_tdata", {24'b0, m_axis_tdata}, 32'd0);
    check("rst_s_tready", {31'b0, s_axis_tready}, 32'd0);
    check("rst_fcs", o_fcs, 32'd0);
    check("rst_done", {31'b0, o_frame_done}, 32'd0);
    @(posedge clk); #1;
    i_reset_n = 1'b1;
    @(negedge clk);
    check("s_tready_after_rst", {31'b0, s_axis_tready}, 32'd1);

    // pin the model against the well-known check value
    pin_crc = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) pin_crc = crc_step(pin_crc, 8'h31 + 8'(i));
    check("model_check_value", ~pin_crc, 32'hCBF43926);

    // "123456789", no pad
    load_123456789();
    b0 = beats; d0 = done_cnt;
    send_frame(9, 1'b0, 1'b0);
    wait_done(d0 + 1);
    check("t1_beats", beats - b0, 32'd13);
    check("t1_fcs_literal", o_fcs, 32'hCBF43926);

    // same frame, padded
    b0 = beats; d0 = done_cnt;
    send_frame(9, 1'b1, 1'b0);
    wait_done(d0 + 1);
    check("t2_beats", beats - b0, 32'd64);

    // 64-byte random frame, pad enabled but not needed
    load_random(64);
    b0 = beats; d0 = done_cnt;
    send_frame(64, 1'b1, 1'b0);
    wait_done(d0 + 1);
    check("t3_beats", beats - b0, 32'd68);

    // single-byte frame, padded
    fbuf[0] = 8'hAA;
    b0 = beats; d0 = done_cnt;
    send_frame(1, 1'b1, 1'b0);
    wait_done(d0 + 1);
    check("t4_beats", beats - b0, 32'd64);

    // three back-to-back frames with stalls and input gaps
    stall = 1'b1;
    d0 = done_cnt;
    load_random(5);   send_frame(5, 1'b1, 1'b1);
    load_random(70);  send_frame(70, 1'b0, 1'b1);
    load_random(20);  send_frame(20, 1'b1, 1'b1);
    wait_done(d0 + 3);
    check("t5_queue_empty", exp_d.size(), 32'd0);

    // random lengths including frames longer than 127 bytes
    d0 = done_cnt;
    for (int f = 0; f < 5; f++) begin
      int len = (f == 0) ? 140 : $urandom_range(1, 130);
      load_random(len);
      send_frame(len, 1'($urandom_range(0, 1)), 1'b1);
    end
    wait_done(d0 + 5);
    stall = 1'b0;

    // reset during PAD of frame A, then frame B
    load_123456789();
    b0 = beats; d0 = done_cnt;
    send_frame(9, 1'b1, 1'b0);
    for (int t = 0; t < 2000 && beats < b0 + 15; t++) @(negedge clk);
    @(posedge clk); #1;
    i_reset_n = 1'b0;
    exp_d.delete(); exp_l.delete(); exp_fcs.delete();
    @(posedge clk); #1;
    i_reset_n = 1'b1;
    @(negedge clk);
    check("mid_rst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    check("mid_rst_s_tready", {31'b0, s_axis_tready}, 32'd1);
    b0 = beats;
    send_frame(9, 1'b0, 1'b0);
    wait_done(d0 + 1);
    check("t6_beats", beats - b0, 32'd13);
    check("t6_fcs_literal", o_fcs, 32'hCBF43926);
    repeat (20) @(negedge clk);
    check("final_queue_empty", exp_d.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/eth_tx_fcs_ctrl.md
ETH_TX_FCS_CTRL -- requirements
Module: eth_tx_fcs_ctrl

Interface
REQ-001 Parameter MIN_FRAME_BYTES, default 60, minimum payload byte count before FCS (pad target).
REQ-002 Parameter POLY, default 32'h04C11DB7, CRC32 polynomial passed to the CRC sub-module.
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 i_reset_n  input  1  reset, synchronous, active-low.
REQ-005 s_axis_tdata  input  8  frame byte from MAC TX path.
REQ-006 s_axis_tvalid  input  1  input byte valid.
REQ-007 s_axis_tlast  input  1  marks final payload byte of frame.
REQ-008 s_axis_tready  output  1  block accepts input byte this cycle.
REQ-009 m_axis_tdata  output  8  payload, pad or FCS byte.
REQ-010 m_axis_tvalid  output  1  output byte valid.
REQ-011 m_axis_tlast  output  1  marks final FCS byte.
REQ-012 m_axis_tready  input  1  downstream accepts output byte.
REQ-013 i_pad_en  input  1  enable zero-padding to MIN_FRAME_BYTES; sampled on first byte of frame.
REQ-014 o_fcs  output  32  FCS of last completed frame, as transmitted (byte0 = o_fcs[7:0]).
REQ-015 o_frame_done  output  1  one-cycle pulse when final FCS byte handshakes on m_axis.

Function
REQ-016 FSM states SHALL be IDLE, DATA, PAD, FCS.
REQ-017 Output stage SHALL be one register; "slot free" = !m_axis_tvalid || m_axis_tready.
REQ-018 s_axis_tready SHALL equal slot free AND state in {IDLE, DATA}; low in PAD and FCS.
REQ-019 Accepted input byte SHALL appear on m_axis_tdata the next cycle (latency 1).
REQ-020 While m_axis_tvalid && !m_axis_tready, m_axis_tdata/tvalid/tlast SHALL hold stable.
REQ-021 IDLE -> DATA on first accepted byte without tlast; IDLE -> PAD/FCS directly on single-byte frame per REQ-023.
REQ-022 CRC state register SHALL reset to 32'hFFFFFFFF at frame start and advance once per payload or pad byte loaded into the output register, via the crc32 sub-module (crc_en = load).
REQ-023 On accepted tlast byte: if i_pad_en latched and byte count < MIN_FRAME_BYTES -> PAD, else -> FCS.
REQ-024 PAD SHALL emit 8'h00 bytes, each included in CRC, until byte count = MIN_FRAME_BYTES, then -> FCS.
REQ-025 Byte counter SHALL be 7 bits, saturating at MIN_FRAME_BYTES; frames longer than 127 bytes SHALL not wrap behaviour.
REQ-026 On the load of the final payload/pad byte, crc_out (reflected, inverted) SHALL be latched into o_fcs.
REQ-027 FCS SHALL emit o_fcs[7:0], [15:8], [23:16], [31:24] in order, one per slot-free cycle; m_axis_tlast high on the fourth only.
REQ-028 On fourth FCS handshake: o_frame_done pulses, CRC state reinitialised, -> IDLE; s_axis_tready may assert the same cycle (back-to-back frames, no idle gap required).
REQ-029 Input bytes with tvalid low SHALL not advance counter, CRC or FSM; gaps mid-frame are legal.

Reset
REQ-030 On i_reset_n low at a clock edge: state IDLE, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0, s_axis_tready 0, o_frame_done 0, o_fcs 0, counter 0, CRC state 32'hFFFFFFFF.
REQ-031 Reset mid-frame SHALL drop the frame silently; no partial FCS emitted after release.
REQ-032 s_axis_tready SHALL rise the first cycle after reset deasserts.

Structure
REQ-033 Shared package eth_pkg SHALL hold CRC_INIT (32'hFFFFFFFF), ETH_MIN_PAYLOAD (60), FCS_BYTES (4) and the FSM state enum.
REQ-034 Exactly one sub-module SHALL be instantiated: crc32 (8-bit data, 32-bit CRC), combinational, with external state register owned by this block.

Verification
REQ-035 Bytes 0x31..0x39 ("123456789"), tlast on 0x39, pad off -> output 9 bytes then 26 39 F4 CB, tlast on CB, o_fcs = 32'hCBF43926.
REQ-036 Same frame, pad on -> 9 payload bytes, 51 bytes 0x00, then 4 FCS bytes matching golden model; total 64 output beats.
REQ-037 64-byte random frame, pad on -> no pad bytes; 68 output beats; FCS matches model.
REQ-038 Random m_axis_tready (50%) and s_axis_tvalid gaps over 3 back-to-back frames -> byte stream identical to no-stall run; o_frame_done pulses exactly 3 times.
REQ-039 Single-byte frame 0xAA, pad on -> 0xAA, 59 zeros, 4 FCS bytes.
REQ-040 i_reset_n low for 1 cycle during PAD of frame A, then frame B ("123456789", pad off) -> only frame B emitted, FCS CB F4 39 26 reversed order as REQ-035.
